// File: rtl/tone_scheduler_pkg.sv
// tone_scheduler_pkg: state encodings, melody IDs, melody priority ranking and tone ROM contents
package tone_scheduler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COLOR, S_LOAD, S_PLAY, S_GAP} state_t;
  localparam logic [1:0] M_START = 2'd0;
  localparam logic [1:0] M_WIN   = 2'd1;
  localparam logic [1:0] M_LOSE  = 2'd2;
  localparam logic [1:0] M_HS    = 2'd3;
  function automatic logic [1:0] rank(input logic [1:0] m);
    return m == M_LOSE ? 2'd3 : m == M_WIN ? 2'd2 : m == M_HS ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [1:0] top_pending(input logic [3:0] p);
    return p[M_LOSE] ? M_LOSE : p[M_WIN] ? M_WIN : p[M_HS] ? M_HS : M_START;
  endfunction
  function automatic logic [8:0] rom_word(input logic [4:0] a);
    logic [8:0] w;
    w = 9'd0;
    case (a)
      5'd0:  w = {4'd4, 4'd4, 1'b0};
      5'd1:  w = {4'd5, 4'd4, 1'b0};
      5'd2:  w = {4'd6, 4'd4, 1'b1};
      5'd8:  w = {4'd6, 4'd3, 1'b0};
      5'd9:  w = {4'd7, 4'd3, 1'b0};
      5'd10: w = {4'd8, 4'd3, 1'b0};
      5'd11: w = {4'd6, 4'd3, 1'b0};
      5'd12: w = {4'd8, 4'd3, 1'b0};
      5'd13: w = {4'd10, 4'd8, 1'b1};
      5'd16: w = {4'd12, 4'd8, 1'b0};
      5'd17: w = {4'd13, 4'd8, 1'b1};
      5'd24: w = {4'd8, 4'd2, 1'b0};
      5'd25: w = {4'd9, 4'd2, 1'b0};
      5'd26: w = {4'd10, 4'd2, 1'b0};
      5'd27: w = {4'd11, 4'd2, 1'b1};
      default: w = 9'd0;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/tone_scheduler_rom.sv
// tone_rom: combinational 32x9 melody ROM, addr {melody,step} -> data {note,dur,last}
module tone_rom
  import tone_scheduler_pkg::*;
(
  input  logic [4:0] addr,
  output logic [8:0] data
);
  assign data = rom_word(addr);
endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler: colour tone / prioritised melody sequencer; in CLK RST_N TICK REQ_COLOR COLOR REQ_*, out TONE_EN TONE_SEL BUSY DONE
module tone_scheduler
  import tone_scheduler_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic       REQ_COLOR,
  input  logic [1:0] COLOR,
  input  logic       REQ_START,
  input  logic       REQ_WIN,
  input  logic       REQ_LOSE,
  input  logic       REQ_HS,
  output logic       TONE_EN,
  output logic [3:0] TONE_SEL,
  output logic       BUSY,
  output logic       DONE
);
  state_t     state;
  logic [3:0] pend, set, eff, clr, cnt;
  logic [1:0] cur, nxt;
  logic [2:0] step;
  logic [8:0] rom;
  logic       last, start, busy;
  assign busy  = state == S_LOAD || state == S_PLAY || state == S_GAP;
  assign set   = {REQ_HS, REQ_LOSE, REQ_WIN, REQ_START} & ~(busy ? 4'b0001 << cur : 4'b0000);
  assign eff   = pend | set;
  assign nxt   = top_pending(eff);
  assign start = |eff && (state == S_IDLE || state == S_COLOR ||
                 ((state == S_PLAY || state == S_GAP) && rank(nxt) > rank(cur)));
  assign clr   = start ? 4'b0001 << nxt : 4'b0000;
  assign BUSY  = busy;
  tone_rom u_rom (.addr({cur, step}), .data(rom));
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state    <= S_IDLE;
      pend     <= 4'd0;
      cur      <= M_START;
      step     <= 3'd0;
      cnt      <= 4'd0;
      last     <= 1'b0;
      TONE_EN  <= 1'b0;
      TONE_SEL <= 4'd0;
      DONE     <= 1'b0;
    end else begin
      pend <= eff & ~clr;
      DONE <= 1'b0;
      if (start) begin
        state   <= S_LOAD;
        cur     <= nxt;
        step    <= 3'd0;
        TONE_EN <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (REQ_COLOR) begin
              state    <= S_COLOR;
              TONE_EN  <= 1'b1;
              TONE_SEL <= {2'b00, COLOR};
            end
          S_COLOR: begin
            TONE_SEL <= {2'b00, COLOR};
            if (!REQ_COLOR) begin
              state   <= S_IDLE;
              TONE_EN <= 1'b0;
            end
          end
          S_LOAD: begin
            state                  <= S_PLAY;
            TONE_EN                <= 1'b1;
            {TONE_SEL, cnt, last}  <= rom;
          end
          S_PLAY:
            if (TICK) begin
              if (cnt == 4'd1) begin
                TONE_EN <= 1'b0;
                DONE    <= last;
                step    <= last ? 3'd0 : step + 3'd1;
                state   <= last ? S_IDLE : S_GAP;
              end else
                cnt <= cnt - 4'd1;
            end
          S_GAP:
            if (TICK) state <= S_LOAD;
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: randomized scoreboard bench for tone_scheduler against a tick-level melody model
module tb_tone_scheduler;
  localparam int START = 0, WIN = 1, LOSE = 2, HS = 3;
  logic       CLK = 1'b0, RST_N = 1'b0, TICK = 1'b0, REQ_COLOR = 1'b0;
  logic [1:0] COLOR = 2'd0;
  logic [3:0] req = 4'd0;
  logic       REQ_START, REQ_WIN, REQ_LOSE, REQ_HS, TONE_EN, BUSY, DONE;
  logic [3:0] TONE_SEL;
  assign {REQ_HS, REQ_LOSE, REQ_WIN, REQ_START} = req;
  typedef struct {int kind; int sel; int val; bit stable;} rec_t;
  rec_t exp_q[$];
  int checks = 0, errors = 0;
  int notes [4][6] = '{'{4, 5, 6, 0, 0, 0}, '{6, 7, 8, 6, 8, 10}, '{12, 13, 0, 0, 0, 0}, '{8, 9, 10, 11, 0, 0}};
  int durs  [4][6] = '{'{4, 4, 4, 0, 0, 0}, '{3, 3, 3, 3, 3, 8}, '{8, 8, 0, 0, 0, 0}, '{2, 2, 2, 2, 0, 0}};
  int len   [4]    = '{3, 6, 2, 4};
  int rnk   [4]    = '{0, 2, 3, 1};
  bit prev = 1'b0, sb, ok;
  int ss, st, sl;

  tone_scheduler dut (
    .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .REQ_COLOR(REQ_COLOR), .COLOR(COLOR),
    .REQ_START(REQ_START), .REQ_WIN(REQ_WIN), .REQ_LOSE(REQ_LOSE), .REQ_HS(REQ_HS),
    .TONE_EN(TONE_EN), .TONE_SEL(TONE_SEL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void push(int kind, int sel, int val, bit stable = 1'b1);
    rec_t r;
    r.kind = kind; r.sel = sel; r.val = val; r.stable = stable;
    exp_q.push_back(r);
  endfunction

  function automatic int total(int m);
    int t;
    t = len[m] - 1;
    for (int j = 0; j < len[m]; j++) t += durs[m][j];
    return t;
  endfunction

  function automatic void exp_full(int m);
    for (int j = 0; j < len[m]; j++) push(0, notes[m][j], durs[m][j]);
    push(2, 0, 0);
  endfunction

  // notes heard when a melody is cut off in the cycle after its k-th tick
  function automatic void exp_cut(int m, int k);
    int r;
    r = k;
    for (int j = 0; j < len[m]; j++) begin
      if (r < durs[m][j]) begin
        push(0, notes[m][j], r);
        return;
      end
      r -= durs[m][j];
      push(0, notes[m][j], durs[m][j]);
      if (r == 0) return;
      r--;
    end
  endfunction

  task automatic emit(int kind, int sel, int val, bit stable);
    rec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected output: got kind %0d sel %0d val %0d, expected none", kind, sel, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.sel != sel || e.val != val || e.stable != stable) begin
        errors++;
        $display("FAIL output record: got kind %0d sel %0d val %0d stable %0d, expected kind %0d sel %0d val %0d stable %0d",
                 kind, sel, val, stable, e.kind, e.sel, e.val, e.stable);
      end
    end
  endtask

  // monitor: a tone segment is reported when TONE_EN drops (note: ticks heard, colour: cycles on)
  always @(negedge CLK) begin
    if (TONE_EN) begin
      if (!prev) begin
        sb = BUSY; ss = int'(TONE_SEL); st = 0; sl = 0; ok = 1'b1;
      end
      sl++;
      if (TICK) st++;
      if (int'(TONE_SEL) != ss) ok = 1'b0;
    end else if (prev) emit(sb ? 0 : 1, ss, sb ? st : sl, ok);
    if (DONE) emit(2, 0, 0, 1'b1);
    prev = TONE_EN;
  end

  task automatic run_mel(int a, int b, int k, int p, bit hold, int extra);
    int e, n, first, hi, lo, ta, col;
    ta = total(a); first = a; col = int'(COLOR);
    if (b < 0 || (k == 0 && b == a) || (k > 0 && k < ta && b == a)) begin
      exp_full(a); e = ta;
    end else if (k == 0) begin
      hi = rnk[a] > rnk[b] ? a : b; lo = hi == a ? b : a; first = hi;
      exp_full(hi); exp_full(lo); e = total(hi) + total(lo);
    end else if (k >= ta) begin
      exp_full(a);
      if (hold && k > ta) push(1, col, (k - ta) * p);
      exp_full(b); e = k + total(b);
    end else if (rnk[b] > rnk[a]) begin
      exp_cut(a, k); exp_full(b); e = k + total(b);
    end else begin
      exp_full(a); exp_full(b); e = ta + total(b);
    end
    n = (e + 2) * p + extra;
    if (hold) push(1, col, n - e * p);
    for (int i = 0; i < n; i++) begin
      TICK = (i % p == p - 1);
      REQ_COLOR = hold;
      req = 4'd0;
      if (i == 0) req[a] = 1'b1;
      if (b >= 0 && i == k * p) req[b] = 1'b1;
      @(negedge CLK);
      if (i == 1) begin
        check("load busy", BUSY, 1);
        check("load silent", TONE_EN, 0);
      end
      if (i == 2) begin
        check("start latency", TONE_EN, 1);
        check("first note", TONE_SEL, notes[first][0]);
      end
      @(posedge CLK); #1;
    end
    TICK = 1'b0; REQ_COLOR = 1'b0; req = 4'd0;
    repeat (6) @(negedge CLK);
    check("idle after melody", BUSY, 0);
    @(posedge CLK); #1;
  endtask

  task automatic run_col(int x, int y, int l, int m);
    push(1, x, l, x == y);
    for (int i = 0; i < l; i++) begin
      REQ_COLOR = 1'b1;
      COLOR = 2'(i >= m ? y : x);
      TICK = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (i == 0) check("colour off before", TONE_EN, 0);
      if (i == 1) check("colour on", TONE_EN, 1);
      if (i == 1) check("colour busy", BUSY, 0);
      if (i == m) check("colour old", TONE_SEL, x);
      if (i == m + 1) check("colour new", TONE_SEL, y);
      @(posedge CLK); #1;
    end
    REQ_COLOR = 1'b0; TICK = 1'b0;
    @(negedge CLK);
    check("colour tail", TONE_EN, 1);
    @(negedge CLK);
    check("colour released", TONE_EN, 0);
    @(posedge CLK); #1;
  endtask

  task automatic run_reset();
    exp_cut(WIN, 10);
    for (int i = 0; i < 50; i++) begin
      TICK = (i % 5 == 4);
      req = 4'd0;
      if (i == 0) req[WIN] = 1'b1;
      if (i == 1) req[HS] = 1'b1;
      @(posedge CLK); #1;
    end
    TICK = 1'b0; req = 4'd0;
    #2 RST_N = 1'b0;
    #1;
    check("reset tone_en", TONE_EN, 0);
    check("reset busy", BUSY, 0);
    check("reset tone_sel", TONE_SEL, 0);
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 30; i++) begin
      TICK = (i % 5 == 4);
      @(negedge CLK);
      check("post-reset busy", BUSY, 0);
      check("post-reset tone_en", TONE_EN, 0);
      @(posedge CLK); #1;
    end
    TICK = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run still going at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b, k, p, x, y, l, m;
    bit hold;
    repeat (3) @(posedge CLK);
    #1;
    check("reset tone_en", TONE_EN, 0);
    check("reset tone_sel", TONE_SEL, 0);
    check("reset busy", BUSY, 0);
    check("reset done", DONE, 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    run_mel(LOSE, -1, 0, 20, 1'b0, 0);
    run_col(2, 2, 50, 25);
    run_mel(START, LOSE, 7, 6, 1'b0, 0);
    run_mel(HS, WIN, 0, 5, 1'b0, 0);
    run_mel(LOSE, LOSE, 5, 5, 1'b0, 0);
    COLOR = 2'd1;
    run_mel(WIN, -1, 0, 4, 1'b1, 3);
    run_reset();
    for (int s = 0; s < 40; s++) begin
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 4)) - 1;
      k = int'($urandom_range(0, total(a) + 2));
      p = int'($urandom_range(4, 8));
      hold = 1'($urandom_range(0, 1));
      COLOR = 2'($urandom_range(0, 3));
      run_mel(a, b, k, p, hold, int'($urandom_range(0, 5)));
    end
    for (int s = 0; s < 15; s++) begin
      x = int'($urandom_range(0, 3));
      y = int'($urandom_range(0, 3));
      l = int'($urandom_range(4, 20));
      m = int'($urandom_range(2, l - 2));
      run_col(x, y, l, m);
    end
    repeat (4) @(posedge CLK);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST_N  input  1  reset, asynchronous, active-low.
REQ-003 TICK  input  1  one-cycle duration tick from the game timer; the unit of note duration.
REQ-004 REQ_COLOR  input  1  level; colour tone requested while high (driven from controller OUT_ENA).
REQ-005 COLOR  input  2  colour index; maps to tone code 0..3.
REQ-006 REQ_START, REQ_WIN, REQ_LOSE, REQ_HS  input  1 each  single-cycle melody request pulses.
REQ-007 TONE_EN  output  1  tone generator enable.
REQ-008 TONE_SEL  output  4  tone code to tone generator; 0..3 colour tones, 4..15 melody tones.
REQ-009 BUSY  output  1  high while a melody is loading, playing or in a gap.
REQ-010 DONE  output  1  one-cycle pulse when a melody completes without preemption.

Function
REQ-011 Each REQ_* pulse SHALL set a sticky pending flag, cleared only when that melody starts.
REQ-012 Melody priority SHALL be LOSE > WIN > HS > START; every melody SHALL override colour tone.
REQ-013 States SHALL be IDLE, COLOR, LOAD, PLAY, GAP.
REQ-014 IDLE/COLOR: any pending flag -> LOAD, with highest pending recorded as current melody, its flag cleared, step=0.
REQ-015 IDLE with REQ_COLOR high and none pending -> COLOR; COLOR with REQ_COLOR low -> IDLE.
REQ-016 In COLOR, TONE_EN=1 and TONE_SEL={2'b00,COLOR} registered, tracking COLOR changes one cycle late.
REQ-017 LOAD SHALL read ROM entry {melody,step} = {note[3:0], dur[3:0], last} and go to PLAY next cycle with TONE_EN=1, TONE_SEL=note, duration counter=dur.
REQ-018 A request pulse in cycle N from IDLE SHALL give TONE_EN=1 in cycle N+2.
REQ-019 PLAY: on each TICK the counter decrements; note ends on the TICK where counter==1; dur=0 means 16 ticks.
REQ-020 TICK coincident with LOAD SHALL NOT count toward duration.
REQ-021 Note end with last=0: step+1, go to GAP with TONE_EN=0; the next TICK -> LOAD.
REQ-022 Note end with last=1: TONE_EN=0, DONE=1 for one cycle, go to IDLE.
REQ-023 A pending melody of strictly higher priority than current SHALL preempt in PLAY or GAP: -> LOAD of new melody, no DONE for preempted one.
REQ-024 A request for the currently playing melody SHALL be dropped (flag not set).
REQ-025 Equal- or lower-priority pending requests SHALL wait and play in priority order after completion.
REQ-026 BUSY SHALL be 1 in LOAD, PLAY, GAP; 0 in IDLE, COLOR.
REQ-027 REQ_COLOR SHALL be ignored while BUSY; colour resumes via IDLE after melody ends if still high.

Reset
REQ-028 RST_N low SHALL asynchronously force state IDLE, all pending flags 0, step 0, counter 0, TONE_EN 0, TONE_SEL 0, BUSY 0, DONE 0.
REQ-029 Reset mid-melody SHALL silence immediately; no melody resumes after release.

Structure
REQ-030 Shared package SHALL hold state encodings, melody IDs (START=0, WIN=1, LOSE=2, HS=3) and ROM contents.
REQ-031 ROM SHALL be a combinational sub-module tone_rom, 32 entries x 9 bits, address {melody[1:0], step[2:0]}.
REQ-032 Melody contents: START 3 notes {4,5,6}, dur 4 each; WIN 6 notes {6,7,8,6,8,10}, dur 3 each, last dur 8; LOSE 2 notes {12 dur 8, 13 dur 8}; HS 4 notes {8,9,10,11}, dur 2 each.

Verification
REQ-033 REQ_LOSE pulse at cycle 10, TICK every 20 cycles -> TONE_EN=1 at cycle 12, TONE_SEL=12 for 8 ticks, one-tick gap, 13 for 8 ticks, DONE pulse once.
REQ-034 REQ_COLOR high with COLOR=2 for 50 cycles -> TONE_SEL=2, TONE_EN=1 from next cycle until one cycle after REQ_COLOR falls.
REQ-035 REQ_START then REQ_LOSE during START note 2 -> START aborted without DONE, LOSE plays fully, DONE once.
REQ-036 REQ_HS and REQ_WIN in same cycle -> WIN plays first, then HS, two DONE pulses.
REQ-037 RST_N low during WIN note 3 -> TONE_EN, BUSY 0 asynchronously; after release stays IDLE with no pending.
REQ-038 REQ_LOSE re-pulsed during LOSE playback -> exactly one LOSE playback, one DONE.
